// File: rtl/am_err_pkg.sv
// Shared types and widths for the approximate-multiplier error monitor.
package am_err_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int SUM_W  = 32;
  localparam int SQ_W   = 48;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Unsigned distance between two products, never wraps.
  function automatic logic [PROD_W-1:0] absDiff(input logic [PROD_W-1:0] a,
                                                input logic [PROD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/am_err_stage.sv
// Stage 1: registers the exact 8x8 product and its distance from the approximate one.
module am_err_stage
  import am_err_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [OP_W-1:0]   i_x,
  input  logic [OP_W-1:0]   i_y,
  input  logic [PROD_W-1:0] i_z,
  output logic [PROD_W-1:0] o_prod,
  output logic [PROD_W-1:0] o_ed,
  output logic              o_valid
);

  logic [PROD_W-1:0] w_prod;
  logic [PROD_W-1:0] r_prod;
  logic [PROD_W-1:0] r_ed;
  logic              r_valid;

  assign w_prod = PROD_W'(i_x) * PROD_W'(i_y);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_prod  <= '0;
      r_ed    <= '0;
    end else begin
      r_valid <= i_load;
      if (i_load) begin
        r_prod <= w_prod;
        r_ed   <= absDiff(w_prod, i_z);
      end
    end
  end

  assign o_prod  = r_prod;
  assign o_ed    = r_ed;
  assign o_valid = r_valid;

endmodule

// File: rtl/unsigned_8x8_err_monitor.sv
// Windowed error statistics for an 8x8 approximate multiplier.
// Define ERR_MONITOR_SQUARE_EN to add the sum-of-squared-error output sum_sq.
module unsigned_8x8_err_monitor
  import am_err_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_x,
  input  logic [OP_W-1:0]   in_y,
  input  logic [PROD_W-1:0] in_z,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sum_ed,
  output logic [PROD_W-1:0] max_ed,
`ifdef ERR_MONITOR_SQUARE_EN
  output logic [SQ_W-1:0]   sum_sq,
`endif
  output logic [LEN_W-1:0]  err_cnt
);

  state_t            r_state;
  logic [LEN_W-1:0]  r_remain;
  logic [SUM_W-1:0]  r_sumEd;
  logic [PROD_W-1:0] r_maxEd;
  logic [LEN_W-1:0]  r_errCnt;
  logic              w_xfer;
  logic              w_startAcc;
  logic              w_s1Valid;
  logic [PROD_W-1:0] w_ed;
  logic [PROD_W-1:0] w_unusedProd;

  assign in_ready   = (r_state == ST_RUN);
  assign busy       = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done       = (r_state == ST_DONE);
  assign w_xfer     = in_valid && in_ready;
  assign w_startAcc = start && (r_state == ST_IDLE);

  am_err_stage u_stage (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_xfer),
    .i_x     (in_x),
    .i_y     (in_y),
    .i_z     (in_z),
    .o_prod  (w_unusedProd),
    .o_ed    (w_ed),
    .o_valid (w_s1Valid)
  );

  // DRAIN waits for stage 1 to empty, so DONE follows stage 2's final update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_remain <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_remain <= len;
            r_state  <= (len == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_xfer) begin
            r_remain <= r_remain - LEN_W'(1);
            if (r_remain == LEN_W'(1)) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!w_s1Valid) r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_startAcc) begin
      r_sumEd  <= '0;
      r_maxEd  <= '0;
      r_errCnt <= '0;
    end else if (w_s1Valid) begin
      r_sumEd  <= r_sumEd + SUM_W'(w_ed);
      r_maxEd  <= (w_ed > r_maxEd) ? w_ed : r_maxEd;
      r_errCnt <= r_errCnt + LEN_W'(w_ed != '0);
    end
  end

`ifdef ERR_MONITOR_SQUARE_EN
  logic [SQ_W-1:0]     r_sumSq;
  logic [2*PROD_W-1:0] w_edSq;

  assign w_edSq = (2*PROD_W)'(w_ed) * (2*PROD_W)'(w_ed);

  always_ff @(posedge clk) begin
    if (rst || w_startAcc) begin
      r_sumSq <= '0;
    end else if (w_s1Valid) begin
      r_sumSq <= r_sumSq + SQ_W'(w_edSq);
    end
  end

  assign sum_sq = r_sumSq;
`endif

  assign sum_ed  = r_sumEd;
  assign max_ed  = r_maxEd;
  assign err_cnt = r_errCnt;

endmodule

// File: doc/unsigned_8x8_err_monitor.md
UNSIGNED_8X8_ERR_MONITOR -- requirements
Module: unsigned_8x8_err_monitor

Interface
REQ-001 Parameter LEN_W, default 16: width of the sample-count and error-count fields.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  one-cycle request to begin a measurement window.
REQ-005 len  input  LEN_W  number of samples in the window; sampled when start is accepted.
REQ-006 in_valid  input  1  a sample is present on in_x, in_y and in_z.
REQ-007 in_ready  output  1  the block accepts a sample this cycle.
REQ-008 in_x, in_y  input  8 each  multiplier operands.
REQ-009 in_z  input  16  approximate product from the upstream 8x8 approximate multiplier.
REQ-010 busy  output  1  window in progress (states RUN or DRAIN).
REQ-011 done  output  1  one-cycle pulse when the results are final.
REQ-012 sum_ed  output  32  sum of absolute error distances |x*y - z| over the window.
REQ-013 max_ed  output  16  largest error distance seen in the window.
REQ-014 err_cnt  output  LEN_W  count of samples whose error distance is nonzero.

Function
REQ-015 The FSM SHALL have four states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start.
- RUN -> DRAIN when the len-th sample is accepted.
- DRAIN -> DONE when the pipeline is empty.
- DONE -> IDLE after one cycle.
REQ-016 A start with len=0 SHALL go IDLE -> DONE directly, with all results equal to 0.
REQ-017 in_ready SHALL be 1 only in RUN; a sample transfers when in_valid and in_ready are both 1.
REQ-018 Stage 1 SHALL register the exact product x*y (16 bits) and ed=|x*y - z| (16 bits) for each transferred sample.
REQ-019 Stage 2 SHALL, one cycle after stage 1:
- add ed to sum_ed;
- update max_ed = max(max_ed, ed);
- increment err_cnt when ed != 0.
REQ-020 Accumulators SHALL clear to 0 in the cycle start is accepted.
REQ-021 The sum SHALL not overflow: 32 bits exceeds 65535*65535.
REQ-022 done SHALL pulse exactly 3 cycles after the clock edge that accepts the last sample (stage 1, then stage 2, then done).
REQ-023 Results SHALL hold their values after done until the next accepted start.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 Gaps in in_valid SHALL stall accumulation without any loss of samples.

Reset
REQ-026 rst=1 SHALL, at the next clock edge:
- put the FSM in IDLE;
- set all outputs to 0 (in_ready, busy, done, sum_ed, max_ed, err_cnt);
- clear the pipeline valid bits.
REQ-027 rst asserted mid-window SHALL abandon the window with no done pulse.
REQ-028 rst SHALL take priority over start.

Configuration
REQ-029 Macro ERR_MONITOR_SQUARE_EN.
- When defined: add output sum_sq [47:0], accumulating ed*ed in stage 2 with the same clear, hold and reset rules as sum_ed.
- When undefined: no sum_sq port and no squaring logic.

Structure
REQ-030 Package am_err_pkg SHALL hold:
- the state enum;
- constants OP_W=8, PROD_W=16, SUM_W=32, SQ_W=48.
REQ-031 Sub-module am_err_stage SHALL be the stage-1 register holding exact product, |diff| and a valid bit; the FSM and accumulators stay in the top.

Verification
REQ-032 len=1; x=255, y=255, z=65025 -> done; sum_ed=0, max_ed=0, err_cnt=0.
REQ-033 len=2; (16,16,z=0) then (3,5,z=17) -> sum_ed=258, max_ed=256, err_cnt=2; with macro defined, sum_sq=65540.
REQ-034 len=4 with in_valid toggling every other cycle -> correct totals; done 3 cycles after the 4th transfer.
REQ-035 start with len=0 -> done one cycle later with all results 0; a start pulsed during RUN is ignored.
REQ-036 rst asserted after 2 of 5 samples -> all outputs 0 on the next cycle, no done; a fresh start then runs normally.
